// File: rtl/sonar_pkg.sv
// Shared types and default constants for the sonar ping sequencer.
package sonar_pkg;

  localparam int unsigned DEF_PERIOD_CYCLES  = 16777216;
  localparam int unsigned DEF_BURST_CYCLES   = 524288;
  localparam int unsigned DEF_TRIGGER_PERIOD = 100;
  localparam int unsigned DEF_ANGLE_WIDTH    = 8;
  localparam int          DEF_ANGLE_MIN      = -30;
  localparam int          DEF_ANGLE_MAX      = 30;
  localparam int unsigned DEF_ANGLE_STEP     = 10;
  localparam int unsigned DEF_RANGE_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    LISTEN = 2'd2,
    REPORT = 2'd3
  } ping_state_t;

  typedef logic signed [DEF_ANGLE_WIDTH-1:0] angle_t;

endpackage

// File: rtl/angle_sequencer.sv
// Beam angle generator: bouncing sweep between the bounds, with a per-ping
// clamped fixed-angle override that leaves the sweep state alone.
module angle_sequencer
  import sonar_pkg::*;
#(
  parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int          ANGLE_MIN   = DEF_ANGLE_MIN,
  parameter int          ANGLE_MAX   = DEF_ANGLE_MAX,
  parameter int unsigned ANGLE_STEP  = DEF_ANGLE_STEP
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          advance_in,
  input  logic                          load_in,
  input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
  output logic signed [ANGLE_WIDTH-1:0] angle_out
);

  localparam int unsigned WW = ANGLE_WIDTH + 1;
  localparam logic signed [WW-1:0] MIN_W  = WW'(ANGLE_MIN);
  localparam logic signed [WW-1:0] MAX_W  = WW'(ANGLE_MAX);
  localparam logic signed [WW-1:0] STEP_W = WW'(ANGLE_STEP);

  logic                          dir_up_q;
  logic                          dir_up_nx;
  logic signed [ANGLE_WIDTH-1:0] sweep_q;
  logic signed [ANGLE_WIDTH-1:0] angle_q;
  logic signed [ANGLE_WIDTH-1:0] sweep_nx;
  logic signed [ANGLE_WIDTH-1:0] fixed_clamped;
  logic signed [WW-1:0]          cur_w;
  logic signed [WW-1:0]          up_w;
  logic signed [WW-1:0]          dn_w;
  logic signed [WW-1:0]          sweep_w;
  logic signed [WW-1:0]          fixed_w;
  logic signed [WW-1:0]          clamp_w;

  // Next sweep position: saturate at a bound first, bounce once sitting on it.
  always_comb begin
    dir_up_nx = dir_up_q;
    cur_w     = {sweep_q[ANGLE_WIDTH-1], sweep_q};
    up_w      = cur_w + STEP_W;
    dn_w      = cur_w - STEP_W;
    sweep_w   = cur_w;
    if (dir_up_q) begin
      if (up_w > MAX_W) begin
        if (cur_w < MAX_W) begin
          sweep_w = MAX_W;
        end else begin
          dir_up_nx = 1'b0;
          sweep_w   = (dn_w < MIN_W) ? MIN_W : dn_w;
        end
      end else begin
        sweep_w = up_w;
      end
    end else begin
      if (dn_w < MIN_W) begin
        if (cur_w > MIN_W) begin
          sweep_w = MIN_W;
        end else begin
          dir_up_nx = 1'b1;
          sweep_w   = (up_w > MAX_W) ? MAX_W : up_w;
        end
      end else begin
        sweep_w = dn_w;
      end
    end
    sweep_nx = sweep_w[ANGLE_WIDTH-1:0];

    fixed_w = {fixed_angle_in[ANGLE_WIDTH-1], fixed_angle_in};
    if (fixed_w < MIN_W) begin
      clamp_w = MIN_W;
    end else if (fixed_w > MAX_W) begin
      clamp_w = MAX_W;
    end else begin
      clamp_w = fixed_w;
    end
    fixed_clamped = clamp_w[ANGLE_WIDTH-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dir_up_q <= 1'b1;
      sweep_q  <= '0;
      angle_q  <= '0;
    end else begin
      if (advance_in) begin
        dir_up_q <= dir_up_nx;
        sweep_q  <= sweep_nx;
      end
      if (load_in) begin
        angle_q <= fixed_clamped;
      end else if (advance_in) begin
        angle_q <= sweep_nx;
      end
    end
  end

  assign angle_out = angle_q;

endmodule

// File: rtl/ping_scheduler.sv
// Sonar ping cycle sequencer: burst timing, listen window with ADC triggers,
// first-echo capture and one valid/ready result per ping.
module ping_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int unsigned TRIGGER_PERIOD = DEF_TRIGGER_PERIOD,
  parameter int unsigned ANGLE_WIDTH    = DEF_ANGLE_WIDTH,
  parameter int          ANGLE_MIN      = DEF_ANGLE_MIN,
  parameter int          ANGLE_MAX      = DEF_ANGLE_MAX,
  parameter int unsigned ANGLE_STEP     = DEF_ANGLE_STEP,
  parameter int unsigned RANGE_WIDTH    = DEF_RANGE_WIDTH
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               enable_in,
  input  logic                               hold_angle_in,
  input  logic signed [ANGLE_WIDTH-1:0]      fixed_angle_in,
  input  logic                               echo_valid_in,
  input  logic [RANGE_WIDTH-1:0]             echo_range_in,
  input  logic                               result_ready_in,
  output logic                               burst_start_out,
  output logic                               burst_active_out,
  output logic                               sample_trigger_out,
  output logic [$clog2(PERIOD_CYCLES)-1:0]   time_since_emission_out,
  output logic signed [ANGLE_WIDTH-1:0]      beam_angle_out,
  output logic                               busy_out,
  output logic                               result_valid_out,
  output logic signed [ANGLE_WIDTH-1:0]      result_angle_out,
  output logic [RANGE_WIDTH-1:0]             result_range_out,
  output logic                               result_timeout_out
);

  localparam int unsigned T_W    = $clog2(PERIOD_CYCLES);
  localparam int unsigned TRIG_W = (TRIGGER_PERIOD > 1) ? $clog2(TRIGGER_PERIOD) : 1;
  localparam logic [T_W-1:0]    LAST_BURST_T = T_W'(BURST_CYCLES - 1);
  localparam logic [T_W-1:0]    LAST_T       = T_W'(PERIOD_CYCLES - 1);
  localparam logic [TRIG_W-1:0] TRIG_LAST    = TRIG_W'(TRIGGER_PERIOD - 1);

  ping_state_t             state_q;
  ping_state_t             state_nx;
  logic [T_W-1:0]          t_q;
  logic [T_W-1:0]          t_nx;
  logic [TRIG_W-1:0]       trig_q;
  logic [TRIG_W-1:0]       trig_nx;
  logic                    captured_q;
  logic                    captured_nx;
  logic [RANGE_WIDTH-1:0]  range_q;
  logic [RANGE_WIDTH-1:0]  range_nx;
  logic                    start_c;
  logic                    advance_c;

  // Next-state, ping timer, trigger divider and first-echo capture.
  always_comb begin
    state_nx    = state_q;
    t_nx        = t_q;
    start_c     = 1'b0;
    advance_c   = 1'b0;
    trig_nx     = '0;
    captured_nx = captured_q;
    range_nx    = range_q;

    case (state_q)
      IDLE: begin
        t_nx = '0;
        if (enable_in) begin
          state_nx = BURST;
          start_c  = 1'b1;
        end
      end
      BURST: begin
        t_nx = t_q + T_W'(1);
        if (t_q == LAST_BURST_T) begin
          state_nx = LISTEN;
        end
      end
      LISTEN: begin
        if (t_q == LAST_T) begin
          state_nx = REPORT;
        end else begin
          t_nx = t_q + T_W'(1);
        end
      end
      REPORT: begin
        if (result_ready_in) begin
          advance_c = 1'b1;
          t_nx      = '0;
          if (enable_in) begin
            state_nx = BURST;
            start_c  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if ((state_nx == LISTEN) && (state_q == LISTEN) && (trig_q != TRIG_LAST)) begin
      trig_nx = trig_q + TRIG_W'(1);
    end

    if (start_c) begin
      captured_nx = 1'b0;
      range_nx    = '0;
    end else if ((state_q == LISTEN) && echo_valid_in && !captured_q) begin
      captured_nx = 1'b1;
      range_nx    = echo_range_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q            <= IDLE;
      t_q                <= '0;
      trig_q             <= '0;
      captured_q         <= 1'b0;
      range_q            <= '0;
      burst_start_out    <= 1'b0;
      burst_active_out   <= 1'b0;
      sample_trigger_out <= 1'b0;
      busy_out           <= 1'b0;
      result_valid_out   <= 1'b0;
      result_angle_out   <= '0;
      result_range_out   <= '0;
      result_timeout_out <= 1'b0;
    end else begin
      state_q            <= state_nx;
      t_q                <= t_nx;
      trig_q             <= trig_nx;
      captured_q         <= captured_nx;
      range_q            <= range_nx;
      burst_start_out    <= start_c;
      burst_active_out   <= (state_nx == BURST);
      sample_trigger_out <= (state_nx == LISTEN) && (trig_nx == '0);
      busy_out           <= (state_nx != IDLE);
      result_valid_out   <= (state_nx == REPORT);
      // Result fields freeze at REPORT entry; an echo on the last cycle still counts.
      if ((state_q == LISTEN) && (state_nx == REPORT)) begin
        result_angle_out   <= beam_angle_out;
        result_range_out   <= captured_nx ? range_nx : '0;
        result_timeout_out <= !captured_nx;
      end
    end
  end

  assign time_since_emission_out = t_q;

  angle_sequencer #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ANGLE_MIN   (ANGLE_MIN),
    .ANGLE_MAX   (ANGLE_MAX),
    .ANGLE_STEP  (ANGLE_STEP)
  ) u_angle_sequencer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .advance_in     (advance_c),
    .load_in        (start_c && hold_angle_in),
    .fixed_angle_in (fixed_angle_in),
    .angle_out      (beam_angle_out)
  );

endmodule

// File: doc/ping_scheduler.md
Name: ping_scheduler

Overview:
- Top-level sequencer for the sonar ping cycle. Issues the burst start pulse, times the transmit burst and listen window, and generates the ADC sample triggers during listening.
- Steps the beam angle in a bouncing sweep and captures the first echo range of each ping.
- Presents one result per ping to the display/storage logic through a valid/ready handshake.
- Replaces the free-running PWM, counters and angle logic in the top level.

Parameters:
- PERIOD_CYCLES, 16777216: full ping period in clocks (burst plus listen).
- BURST_CYCLES, 524288: transmit burst length in clocks; must be less than PERIOD_CYCLES.
- TRIGGER_PERIOD, 100: clocks between sample triggers (1 MHz at 100 MHz).
- ANGLE_WIDTH, 8: signed beam angle width.
- ANGLE_MIN, -30: lower sweep bound in degrees; must be ≤ 0.
- ANGLE_MAX, 30: upper sweep bound in degrees; must be ≥ 0.
- ANGLE_STEP, 10: sweep increment in degrees; must be > 0.
- RANGE_WIDTH, 16: echo range width.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  run pings while high.
- hold_angle_in  input  1  use fixed_angle_in instead of the sweep.
- fixed_angle_in  input  ANGLE_WIDTH  fixed angle (signed).
- echo_valid_in  input  1  echo detected this cycle.
- echo_range_in  input  RANGE_WIDTH  range accompanying echo_valid_in.
- result_ready_in  input  1  consumer accepts the result.
- burst_start_out  output  1  one-cycle pulse at the first burst cycle; resets the downstream datapath.
- burst_active_out  output  1  gates the transmitter outputs.
- sample_trigger_out  output  1  one-cycle ADC conversion trigger.
- time_since_emission_out  output  $clog2(PERIOD_CYCLES)  ping cycle index t.
- beam_angle_out  output  ANGLE_WIDTH  signed angle for the current ping.
- busy_out  output  1  high in any state except IDLE.
- result_valid_out  output  1  result available.
- result_angle_out  output  ANGLE_WIDTH  angle of the reported ping.
- result_range_out  output  RANGE_WIDTH  first echo range; 0 on timeout.
- result_timeout_out  output  1  no echo was captured in the listen window.

Behaviour:
- Reset
  - Asynchronous: while rst_in is low, all outputs are 0, state is IDLE, direction is up, and the angle register is 0.
  - Asserting reset mid-ping drops burst_active_out immediately. No result is produced for the aborted ping.
- States: IDLE, BURST, LISTEN, REPORT. All outputs are registered.
- IDLE
  - t is held at 0.
  - When enable_in is high, the next cycle enters BURST.
- BURST
  - The entry cycle has t=0; burst_start_out is high on that cycle only.
  - burst_active_out is high for t in [0, BURST_CYCLES-1].
  - echo_valid_in is ignored (transmit crosstalk).
  - The cycle after t=BURST_CYCLES-1 enters LISTEN.
- LISTEN
  - Covers t in [BURST_CYCLES, PERIOD_CYCLES-1].
  - sample_trigger_out is high when (t-BURST_CYCLES) mod TRIGGER_PERIOD == 0.
  - The first echo_valid_in in LISTEN latches echo_range_in and sets the captured flag. Later echoes are ignored.
  - An echo on t=PERIOD_CYCLES-1 is captured.
  - The cycle after t=PERIOD_CYCLES-1 enters REPORT.
- REPORT
  - result_valid_out is high. result_angle_out, result_range_out and result_timeout_out are stable until the handshake.
  - No ping starts while result_ready_in is low (backpressure stall). t holds at PERIOD_CYCLES-1.
  - On a cycle with result_valid_out && result_ready_in:
    - result_valid_out deasserts next cycle.
    - The angle advances.
    - If enable_in is high that cycle, the next cycle is BURST (burst_start_out asserted); otherwise the next state is IDLE.
- enable_in deasserted mid-ping: the current ping completes and reports, then the block goes to IDLE.
- Angle rules
  - beam_angle_out is constant from burst start through REPORT.
  - Sweep: add ANGLE_STEP when direction is up, subtract when down.
  - If the result would exceed ANGLE_MAX, output ANGLE_MAX when the current angle is below it. If the current angle is already ANGLE_MAX, reverse direction and step down.
  - The same rule applies, mirrored, at ANGLE_MIN.
  - hold_angle_in, when high at burst start, loads fixed_angle_in clamped to [ANGLE_MIN, ANGLE_MAX] for that ping. Sweep state is untouched.
- Arithmetic: angle arithmetic is signed, computed ANGLE_WIDTH+1 wide before clamping. t counts 0 to PERIOD_CYCLES-1 and never wraps inside a ping.

Decomposition:
- sonar_pkg holds:
  - the ping_state_t enum (IDLE/BURST/LISTEN/REPORT);
  - the typedef angle_t as a signed ANGLE_WIDTH-bit value;
  - default constants for PERIOD_CYCLES, BURST_CYCLES, TRIGGER_PERIOD and the angle bounds.
- Sub-module angle_sequencer holds:
  - the direction and angle registers;
  - inputs advance_in, load_in, fixed_angle_in;
  - output angle_out with the bounce/clamp logic.
- The trigger divider stays inline.

Test Plan:
All scenarios use PERIOD_CYCLES=40, BURST_CYCLES=8, TRIGGER_PERIOD=5, ANGLE_MIN=-20, ANGLE_MAX=20, ANGLE_STEP=10.
1. Release reset, enable_in=1 at cycle 0 -> burst_start_out at cycle 1 with t=0; burst_active_out high for t 0..7; sample_trigger_out at t=8,13,18,23,28,33,38 (7 pulses); result_valid_out rises at t=39+1.
2. echo_valid_in at t=3 with range 77, at t=20 with range 123, and at t=30 with range 50 -> result_range_out=123, result_timeout_out=0, result_angle_out=0.
3. No echo in the ping -> result_timeout_out=1, result_range_out=0.
4. result_ready_in held at 1 over 8 pings -> reported angles 0,10,20,10,0,-10,-20,-10; next burst_start_out follows each handshake by exactly one cycle.
5. result_ready_in low for 100 cycles -> result_valid_out stays high, result fields stay stable, no burst_start_out; after ready rises, burst_start_out occurs one cycle later.
6. enable_in dropped at t=15 -> the ping completes and reports, then IDLE with busy_out=0. In a separate ping, rst_in low at t=10 -> burst_active_out drops the same cycle and beam_angle_out=0. hold_angle_in=1 with fixed_angle_in=-50 -> beam_angle_out=-20.
